// File: rtl/apb_txn_engine.sv
// Single-outstanding APB3 master: takes one command on a valid/ready port,
// runs the setup/access transfer with a bounded pready wait, and returns a one-cycle response.
`timescale 1ns/1ps
module apb_txn_engine #(
  parameter int unsigned ADDR_WIDTH  = 20,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned BUS_TIMEOUT = 100,
  parameter int unsigned TIMER_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [63:0]           cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  psel,
  output logic                  penable,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic [DATA_WIDTH-1:0] pwdata,
  output logic                  pwrite,
  input  logic [DATA_WIDTH-1:0] prdata,
  input  logic                  pready,
  input  logic                  pslverr
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t                 state, state_d;
  logic [TIMER_WIDTH-1:0] bus_timer, bus_timer_d;
  logic                   psel_d, penable_d, pwrite_d;
  logic [ADDR_WIDTH-1:0]  paddr_d;
  logic [DATA_WIDTH-1:0]  pwdata_d;
  logic                   rsp_valid_d, rsp_err_d;
  logic [DATA_WIDTH-1:0]  rsp_rdata_d;
  logic                   timed_out;

  // Upper command address bits are deliberately dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^cmd_addr[63:ADDR_WIDTH];

  assign cmd_ready = (state == IDLE);
  assign timed_out = (bus_timer == TIMER_WIDTH'(BUS_TIMEOUT));

  always_comb begin
    state_d     = state;
    bus_timer_d = bus_timer;
    psel_d      = psel;
    penable_d   = penable;
    pwrite_d    = pwrite;
    paddr_d     = paddr;
    pwdata_d    = pwdata;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata;
    rsp_err_d   = rsp_err;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          psel_d    = 1'b1;
          penable_d = 1'b0;
          pwrite_d  = cmd_write;
          paddr_d   = cmd_addr[ADDR_WIDTH-1:0];
          pwdata_d  = cmd_write ? cmd_wdata : '0;
          state_d   = SETUP;
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        state_d   = ACCESS;
      end
      ACCESS: begin
        // pready wins over the timer, so a slave answering on the last allowed cycle is not an error.
        if (pready || timed_out) begin
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          pwrite_d    = 1'b0;
          paddr_d     = '0;
          pwdata_d    = '0;
          bus_timer_d = '0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = pready ? pslverr : 1'b1;
          rsp_rdata_d = (pready && !pwrite) ? prdata : '0;
          state_d     = DONE;
        end else begin
          bus_timer_d = bus_timer + TIMER_WIDTH'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      bus_timer <= '0;
      psel      <= 1'b0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state     <= state_d;
      bus_timer <= bus_timer_d;
      psel      <= psel_d;
      penable   <= penable_d;
      pwrite    <= pwrite_d;
      paddr     <= paddr_d;
      pwdata    <= pwdata_d;
      rsp_valid <= rsp_valid_d;
      rsp_rdata <= rsp_rdata_d;
      rsp_err   <= rsp_err_d;
    end
  end

endmodule

// File: tb/tb_apb_txn_engine.sv
// Bench for apb_txn_engine: directed plan items plus randomized transactions,
// each checked against a transaction-level expectation of the APB/response behaviour.
`timescale 1ns/1ps
module tb_apb_txn_engine;

  localparam int unsigned AW = 20;
  localparam int unsigned DW = 32;
  localparam int unsigned TO = 100;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_write = 1'b0;
  logic [63:0]   cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          psel, penable, pwrite;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata;
  logic [DW-1:0] prdata = '0;
  logic          pready = 1'b0;
  logic          pslverr = 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  apb_txn_engine #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .BUS_TIMEOUT(TO),
    .TIMER_WIDTH(8)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .psel(psel), .penable(penable), .paddr(paddr), .pwdata(pwdata), .pwrite(pwrite),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic accept(input bit wr, input logic [63:0] addr, input logic [DW-1:0] wd, input bit keep);
    int n = 0;
    while (!cmd_ready && n < 300) begin
      step();
      n++;
    end
    chk("ready_wait", 64'(n < 300), 64'd1);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = wd;
    step();
    if (!keep) cmd_valid = 1'b0;
  endtask

  // Called one cycle after the accept edge; waits = access cycles with pready low (>100 means never ready).
  task automatic complete(input bit wr, input logic [63:0] addr, input logic [DW-1:0] wd,
                          input int waits, input logic [DW-1:0] rd, input bit serr);
    logic [AW-1:0] ea;
    logic [DW-1:0] ew, exp_rd;
    bit exp_err;
    int exp_acc, acc, bad;
    bit done;
    ea      = addr[AW-1:0];
    ew      = wr ? wd : '0;
    exp_acc = (waits > int'(TO)) ? int'(TO) + 1 : waits + 1;
    exp_err = (waits > int'(TO)) ? 1'b1 : serr;
    exp_rd  = (waits > int'(TO) || wr) ? '0 : rd;

    chk("setup_psel", psel, 1);
    chk("setup_penable", penable, 0);
    chk("setup_paddr", paddr, ea);
    chk("setup_pwrite", pwrite, wr);
    chk("setup_pwdata", pwdata, ew);
    chk("busy_not_ready", cmd_ready, 0);
    step();
    chk("access_penable", penable, 1);
    chk("access_psel", psel, 1);

    acc = 0; bad = 0; done = 0;
    while (!done && acc < 300) begin
      pready  = (acc >= waits);
      prdata  = pready ? rd : $urandom;
      pslverr = pready ? serr : 1'($urandom);
      step();
      acc++;
      if (rsp_valid) done = 1;
      else if (!(psel && penable && paddr == ea && pwrite == wr && pwdata == ew)) bad++;
    end
    pready = 1'b0; pslverr = 1'b0; prdata = $urandom;

    chk("access_hold", 64'(bad), 0);
    chk("access_cycles", 64'(acc), 64'(exp_acc));
    chk("rsp_valid", rsp_valid, 1);
    chk("rsp_err", rsp_err, exp_err);
    chk("rsp_rdata", rsp_rdata, exp_rd);
    chk("end_psel", psel, 0);
    chk("end_penable", penable, 0);
    chk("end_paddr", paddr, 0);
    chk("end_pwdata", pwdata, 0);
    chk("end_pwrite", pwrite, 0);
    step();
    chk("rsp_one_cycle", rsp_valid, 0);
    chk("ready_after_done", cmd_ready, 1);
    chk("rsp_err_hold", rsp_err, exp_err);
    chk("rsp_rdata_hold", rsp_rdata, exp_rd);
  endtask

  task automatic txn(input bit wr, input logic [63:0] addr, input logic [DW-1:0] wd,
                     input int waits, input logic [DW-1:0] rd, input bit serr);
    accept(wr, addr, wd, 1'b0);
    complete(wr, addr, wd, waits, rd, serr);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_psel"}, psel, 0);
    chk({tag, "_penable"}, penable, 0);
    chk({tag, "_pwrite"}, pwrite, 0);
    chk({tag, "_paddr"}, paddr, 0);
    chk({tag, "_pwdata"}, pwdata, 0);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_rdata"}, rsp_rdata, 0);
    chk({tag, "_rsp_err"}, rsp_err, 0);
  endtask

  initial begin
    int fall, rise, badp;
    #2 reset_n = 1'b0;
    #3;
    chk_all_zero("reset");
    repeat (3) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    step();
    chk("reset_ready", cmd_ready, 1);

    // Write, zero wait
    txn(1'b1, 64'h0000_1234, 32'hDEAD_BEEF, 0, 32'h0, 1'b0);
    // Read, 3 wait states
    txn(1'b0, 64'h000A_BCDE, 32'h1111_2222, 3, 32'h5A5A_0001, 1'b0);
    // Slave error on write
    txn(1'b1, 64'h0000_0040, 32'h0BAD_F00D, 0, 32'h0, 1'b1);
    // Timeout, then boundary: ready on the last allowed access cycle
    txn(1'b0, 64'h0000_0100, 32'h0, 1000, 32'h1234_5678, 1'b0);
    txn(1'b0, 64'h0000_0104, 32'h0, 100, 32'hCAFE_0100, 1'b0);
    txn(1'b0, 64'h0000_0108, 32'h0, 0, 32'h7777_8888, 1'b0);

    // Address truncation and backpressure: second command held valid during the first
    accept(1'b0, 64'hFFFF_FFFF_FFF0_0010, 32'h0, 1'b1);
    cmd_write = 1'b1;
    cmd_addr  = 64'h0000_0000_0002_2220;
    cmd_wdata = 32'hA5A5_5A5A;
    chk("trunc_paddr", paddr, 20'h00010);
    chk("trunc_pwrite", pwrite, 0);
    fall = -1; rise = -1; badp = 0;
    pready = 1'b1;
    prdata = 32'h0;
    for (int k = 0; k < 20 && rise < 0; k++) begin
      step();
      if (fall < 0 && !psel) fall = cyc;
      else if (fall < 0 && paddr != 20'h00010) badp++;
      else if (fall >= 0 && psel) rise = cyc;
    end
    cmd_valid = 1'b0;
    pready = 1'b0;
    chk("bp_first_addr_hold", 64'(badp), 0);
    chk("bp_second_accepted", 64'(rise >= 0), 1);
    chk("bp_idle_gap", 64'(rise - fall), 2);
    complete(1'b1, 64'h0000_0000_0002_2220, 32'hA5A5_5A5A, 0, 32'h0, 1'b0);

    // Reset mid-access
    accept(1'b0, 64'h0000_0BEE, 32'h0, 1'b0);
    step();
    chk("pre_reset_penable", penable, 1);
    #2 reset_n = 1'b0;
    #1;
    chk_all_zero("midreset");
    chk("midreset_ready", cmd_ready, 1);
    pready = 1'b1;
    repeat (2) step();
    chk("midreset_no_rsp", rsp_valid, 0);
    pready = 1'b0;
    @(negedge clk) reset_n = 1'b1;
    step();
    chk("post_reset_ready", cmd_ready, 1);
    chk("post_reset_no_rsp", rsp_valid, 0);
    txn(1'b0, 64'h0000_0C00, 32'h0, 2, 32'h0102_0304, 1'b0);

    // Randomized transactions
    for (int i = 0; i < 25; i++) begin
      bit wr, se;
      int w;
      logic [63:0] a;
      logic [DW-1:0] d, r;
      wr = 1'($urandom);
      se = ($urandom_range(0, 3) == 0);
      w  = ($urandom_range(0, 11) == 0) ? 1000 : int'($urandom_range(0, 5));
      a  = {$urandom, $urandom};
      d  = $urandom;
      r  = $urandom;
      txn(wr, a, d, w, r, se);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
